// File: rtl/imem_arbiter_pkg.sv
// Shared configuration for the instruction-memory arbiter.
// Holds the instruction width, the NOP returned on misaligned fetches,
// the arbiter state encoding and a small alignment helper.
package imem_arbiter_pkg;

   localparam int INST_WIDTH = 32;

   // Canonical RISC-V NOP (addi x0, x0, 0), returned on a misaligned fetch
   localparam logic [INST_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      ARB_BOOT = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_e;

   // Word accesses only: any nonzero byte offset is an alignment error
   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return |byte_off;
   endfunction

endpackage

// File: rtl/imem_arb_resp.sv
// One-cycle response tracker shared by the fetch and loader ports.
// Ports: set_i/owner_load_i/err_i capture an accepted access needing a
// response; mem_rdata_i is routed to whichever port owns the response.
// Latency: response one cycle after acceptance; no backpressure.
module imem_arb_resp
   import imem_arbiter_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  set_i,         // accepted access that needs a response
   input  logic                  owner_load_i,  // 1 = loader owns it, 0 = fetch
   input  logic                  err_i,         // access was misaligned
   input  logic [INST_WIDTH-1:0] mem_rdata_i,
   output logic                  fetch_rvalid_o,
   output logic [INST_WIDTH-1:0] fetch_rdata_o,
   output logic                  fetch_err_o,
   output logic                  load_rvalid_o,
   output logic [INST_WIDTH-1:0] load_rdata_o,
   output logic                  load_err_o
);

   logic pend_q, pend_d;
   logic owner_q, owner_d;
   logic err_q, err_d;

   // Only one access can be accepted per cycle, so a single slot suffices
   assign pend_d  = set_i;
   assign owner_d = owner_load_i;
   assign err_d   = err_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q  <= 1'b0;
         owner_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   assign fetch_rvalid_o = pend_q & ~owner_q;
   assign load_rvalid_o  = pend_q & owner_q;
   assign fetch_err_o    = fetch_rvalid_o & err_q;
   assign load_err_o     = load_rvalid_o & err_q;

   // On error the memory was never read, so substitute a safe value
   always_comb begin
      fetch_rdata_o = '0;
      load_rdata_o  = '0;
      if (fetch_rvalid_o) begin
         fetch_rdata_o = err_q ? NOP_INSTR : mem_rdata_i;
      end
      if (load_rvalid_o) begin
         load_rdata_o = err_q ? '0 : mem_rdata_i;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous instruction memory between the fetch
// stage and the program loader. BOOT phase lets only the loader in until
// load_done_i; RUN phase gives fetch priority, with the loader force-granted
// after LOAD_STARVE_MAX consecutive denied cycles. Misaligned accesses are
// granted but never reach memory; they return an error response next cycle.
// Ports: fetch_* (IF stage), load_* (loader), load_done_i, boot_o, mem_* (macro).
// Optional macro IMEM_ARB_PERF_EN adds perf_fetch_stall_o / perf_load_force_o.
// Latency: grants combinational, read/error response exactly one cycle later.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int MEM_SIZE        = 1024,
   parameter int LOAD_STARVE_MAX = 8,
   parameter int BOOT_HOLD       = 1,
   localparam int WAW            = $clog2(MEM_SIZE),
   localparam int AW             = WAW + 2
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fetch_req_i,
   input  logic [AW-1:0]         fetch_addr_i,
   output logic                  fetch_gnt_o,
   output logic                  fetch_rvalid_o,
   output logic [INST_WIDTH-1:0] fetch_rdata_o,
   output logic                  fetch_err_o,
   input  logic                  load_req_i,
   input  logic                  load_we_i,
   input  logic [AW-1:0]         load_addr_i,
   input  logic [INST_WIDTH-1:0] load_wdata_i,
   output logic                  load_gnt_o,
   output logic                  load_rvalid_o,
   output logic [INST_WIDTH-1:0] load_rdata_o,
   output logic                  load_err_o,
   input  logic                  load_done_i,
   output logic                  boot_o,
`ifdef IMEM_ARB_PERF_EN
   output logic [31:0]           perf_fetch_stall_o,
   output logic [31:0]           perf_load_force_o,
`endif
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [WAW-1:0]        mem_addr_o,
   output logic [INST_WIDTH-1:0] mem_wdata_o,
   input  logic [INST_WIDTH-1:0] mem_rdata_i
);

   localparam arb_state_e RST_STATE  = (BOOT_HOLD != 0) ? ARB_BOOT : ARB_RUN;
   localparam logic [7:0] STARVE_MAX = 8'(LOAD_STARVE_MAX);

   arb_state_e state_q, state_d;
   logic [7:0] starve_q, starve_d;

   logic fetch_mis, load_mis;
   logic fetch_gnt, load_gnt, force_gnt;
   logic rsp_set, rsp_err;

   assign fetch_mis = is_misaligned(fetch_addr_i[1:0]);
   assign load_mis  = is_misaligned(load_addr_i[1:0]);

   // Grants are suppressed while reset is held so the memory stays idle
   always_comb begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
      force_gnt = 1'b0;
      if (!rst_i) begin
         if (state_q == ARB_BOOT) begin
            load_gnt = load_req_i;
         end else begin
            // Forced grant only counts when it actually overrides fetch
            force_gnt = load_req_i & fetch_req_i & (starve_q == STARVE_MAX);
            fetch_gnt = fetch_req_i & ~force_gnt;
            load_gnt  = load_req_i & (~fetch_req_i | force_gnt);
         end
      end
   end

   assign fetch_gnt_o = fetch_gnt;
   assign load_gnt_o  = load_gnt;

   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = rst_i ? '0 : load_wdata_i;
      if (fetch_gnt) begin
         mem_en_o   = ~fetch_mis;
         mem_addr_o = fetch_addr_i[AW-1:2];
      end else if (load_gnt) begin
         mem_en_o   = ~load_mis;
         mem_we_o   = load_we_i & ~load_mis;
         mem_addr_o = load_addr_i[AW-1:2];
      end
   end

   // Every fetch answers; a loader answers on read-back or on any error
   assign rsp_set = fetch_gnt | (load_gnt & (load_mis | ~load_we_i));
   assign rsp_err = fetch_gnt ? fetch_mis : load_mis;

   always_comb begin
      state_d = state_q;
      if (state_q == ARB_BOOT && load_done_i) begin
         state_d = ARB_RUN;
      end
   end

   always_comb begin
      starve_d = '0;
      if (state_q == ARB_RUN && load_req_i && !load_gnt) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= RST_STATE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   assign boot_o = (state_q == ARB_BOOT);

   imem_arb_resp u_resp (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .set_i          (rsp_set),
      .owner_load_i   (load_gnt),
      .err_i          (rsp_err),
      .mem_rdata_i    (mem_rdata_i),
      .fetch_rvalid_o (fetch_rvalid_o),
      .fetch_rdata_o  (fetch_rdata_o),
      .fetch_err_o    (fetch_err_o),
      .load_rvalid_o  (load_rvalid_o),
      .load_rdata_o   (load_rdata_o),
      .load_err_o     (load_err_o)
   );

`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_force_q, perf_force_d;

   assign perf_stall_d = (state_q == ARB_RUN && fetch_req_i && !fetch_gnt)
                         ? perf_stall_q + 32'd1 : perf_stall_q;
   assign perf_force_d = force_gnt ? perf_force_q + 32'd1 : perf_force_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_stall_q <= '0;
         perf_force_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_force_q <= perf_force_d;
      end
   end

   assign perf_fetch_stall_o = perf_stall_q;
   assign perf_load_force_o  = perf_force_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table for boot, alignment and
// ordering, plus hand sequences for starvation, throughput and reset.
module tb_imem_arbiter;

   localparam int AW  = 12;
   localparam int WAW = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [11:0] fetch_addr = '0;
   logic        fetch_gnt, fetch_rvalid, fetch_err;
   logic [31:0] fetch_rdata;
   logic        load_req = 1'b0, load_we = 1'b0, load_done = 1'b0;
   logic [11:0] load_addr = '0;
   logic [31:0] load_wdata = '0;
   logic        load_gnt, load_rvalid, load_err;
   logic [31:0] load_rdata;
   logic        boot;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_stall, perf_force;
`endif

   logic [31:0] mem [1024];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.MEM_SIZE(1024), .LOAD_STARVE_MAX(8), .BOOT_HOLD(1)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .fetch_req_i    (fetch_req),
      .fetch_addr_i   (fetch_addr),
      .fetch_gnt_o    (fetch_gnt),
      .fetch_rvalid_o (fetch_rvalid),
      .fetch_rdata_o  (fetch_rdata),
      .fetch_err_o    (fetch_err),
      .load_req_i     (load_req),
      .load_we_i      (load_we),
      .load_addr_i    (load_addr),
      .load_wdata_i   (load_wdata),
      .load_gnt_o     (load_gnt),
      .load_rvalid_o  (load_rvalid),
      .load_rdata_o   (load_rdata),
      .load_err_o     (load_err),
      .load_done_i    (load_done),
      .boot_o         (boot),
`ifdef IMEM_ARB_PERF_EN
      .perf_fetch_stall_o (perf_stall),
      .perf_load_force_o  (perf_force),
`endif
      .mem_en_o       (mem_en),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_rdata_i    (mem_rdata)
   );

   // Synchronous single-port memory model
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        fr;  logic [11:0] fa;
      logic        lr;  logic lw; logic [11:0] la; logic [31:0] lwd; logic done;
      logic        e_fg, e_lg, e_en, e_we; logic [9:0] e_ma;
      logic        e_fv, e_fe; logic [31:0] e_fd;
      logic        e_lv, e_le; logic [31:0] e_ld;
      logic        e_boot;
   } vec_t;

   function automatic vec_t mk(
      logic fr, logic [11:0] fa, logic lr, logic lw, logic [11:0] la,
      logic [31:0] lwd, logic done,
      logic e_fg, logic e_lg, logic e_en, logic e_we, logic [9:0] e_ma,
      logic e_fv, logic e_fe, logic [31:0] e_fd,
      logic e_lv, logic e_le, logic [31:0] e_ld, logic e_boot);
      vec_t v;
      v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd; v.done = done;
      v.e_fg = e_fg; v.e_lg = e_lg; v.e_en = e_en; v.e_we = e_we; v.e_ma = e_ma;
      v.e_fv = e_fv; v.e_fe = e_fe; v.e_fd = e_fd;
      v.e_lv = e_lv; v.e_le = e_le; v.e_ld = e_ld; v.e_boot = e_boot;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic [11:0] fa, input logic lr,
                        input logic lw, input logic [11:0] la, input logic [31:0] lwd,
                        input logic done);
      fetch_req = fr; fetch_addr = fa;
      load_req = lr; load_we = lw; load_addr = la; load_wdata = lwd;
      load_done = done;
   endtask

   function automatic logic [31:0] exp_word(int k);
      if (k == 1) return 32'hDEAD_BEEF;
      if (k == 2) return 32'h1234_5678;
      return 32'hA500_0000 | 32'(k);
   endfunction

   vec_t vecs[11];

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = 32'hA500_0000 | 32'(k);

      //              fr fa      lr lw la      lwd           dn  fg lg en we ma  fv fe fd            lv le ld            boot
      vecs[0]  = mk(1, 12'h000, 1, 1, 12'h004, 32'hDEADBEEF, 0,  0, 1, 1, 1, 1,  0, 0, 0,            0, 0, 0,            1);
      vecs[1]  = mk(1, 12'h000, 1, 1, 12'h003, 32'h11111111, 0,  0, 1, 0, 0, 0,  0, 0, 0,            0, 0, 0,            1);
      vecs[2]  = mk(1, 12'h000, 1, 0, 12'h004, 32'h0,        1,  0, 1, 1, 0, 1,  0, 0, 0,            1, 1, 0,            1);
      vecs[3]  = mk(1, 12'h004, 0, 0, 12'h000, 32'h0,        0,  1, 0, 1, 0, 1,  0, 0, 0,            1, 0, 32'hDEADBEEF, 0);
      vecs[4]  = mk(1, 12'h006, 0, 0, 12'h000, 32'h0,        1,  1, 0, 0, 0, 0,  1, 0, 32'hDEADBEEF, 0, 0, 0,            0);
      vecs[5]  = mk(1, 12'h000, 1, 0, 12'h000, 32'h0,        0,  1, 0, 1, 0, 0,  1, 1, 32'h00000013, 0, 0, 0,            0);
      vecs[6]  = mk(0, 12'h000, 0, 0, 12'h000, 32'h0,        0,  0, 0, 0, 0, 0,  1, 0, 32'hA5000000, 0, 0, 0,            0);
      vecs[7]  = mk(0, 12'h000, 1, 0, 12'h003, 32'h0,        0,  0, 1, 0, 0, 0,  0, 0, 0,            0, 0, 0,            0);
      vecs[8]  = mk(0, 12'h000, 1, 1, 12'h008, 32'h12345678, 0,  0, 1, 1, 1, 2,  0, 0, 0,            1, 1, 0,            0);
      vecs[9]  = mk(1, 12'h008, 0, 0, 12'h000, 32'h0,        0,  1, 0, 1, 0, 2,  0, 0, 0,            0, 0, 0,            0);
      vecs[10] = mk(0, 12'h000, 0, 0, 12'h000, 32'h0,        0,  0, 0, 0, 0, 0,  1, 0, 32'h12345678, 0, 0, 0,            0);

      // Reset state, with requests active to show nothing leaks through
      drive(1, 12'h000, 1, 1, 12'h004, 32'hCAFE_F00D, 0);
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_boot",   32'(boot), 1);
      chk("rst_fgnt",   32'(fetch_gnt), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_frv",    32'(fetch_rvalid), 0);
      chk("rst_lrv",    32'(load_rvalid), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].lwd, vecs[i].done);
         #1;
         chk($sformatf("v%0d_fgnt", i), 32'(fetch_gnt), 32'(vecs[i].e_fg));
         chk($sformatf("v%0d_lgnt", i), 32'(load_gnt), 32'(vecs[i].e_lg));
         chk($sformatf("v%0d_en", i),   32'(mem_en), 32'(vecs[i].e_en));
         chk($sformatf("v%0d_we", i),   32'(mem_we), 32'(vecs[i].e_we));
         if (vecs[i].e_en) chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_ma));
         chk($sformatf("v%0d_frv", i),  32'(fetch_rvalid), 32'(vecs[i].e_fv));
         chk($sformatf("v%0d_ferr", i), 32'(fetch_err), 32'(vecs[i].e_fe));
         chk($sformatf("v%0d_fdat", i), fetch_rdata, vecs[i].e_fd);
         chk($sformatf("v%0d_lrv", i),  32'(load_rvalid), 32'(vecs[i].e_lv));
         chk($sformatf("v%0d_lerr", i), 32'(load_err), 32'(vecs[i].e_le));
         chk($sformatf("v%0d_ldat", i), load_rdata, vecs[i].e_ld);
         chk($sformatf("v%0d_boot", i), 32'(boot), 32'(vecs[i].e_boot));
         @(negedge clk);
      end

      // Starvation: second forced grant 9 cycles after the first proves the counter cleared
      for (int i = 0; i < 18; i++) begin
         drive(1, 12'h000, 1, 0, 12'h008, 32'h0, 0);
         #1;
         chk($sformatf("stv%0d_lgnt", i), 32'(load_gnt), 32'(i == 8 || i == 17));
         chk($sformatf("stv%0d_fgnt", i), 32'(fetch_gnt), 32'(!(i == 8 || i == 17)));
         if (i == 9) begin
            chk("stv_lrv",  32'(load_rvalid), 1);
            chk("stv_ldat", load_rdata, 32'h1234_5678);
            chk("stv_frv",  32'(fetch_rvalid), 0);
`ifdef IMEM_ARB_PERF_EN
            chk("perf_force", perf_force, 1);
            chk("perf_stall", perf_stall, 1);
`endif
         end
         @(negedge clk);
      end
      drive(0, 12'h000, 0, 0, 12'h000, 32'h0, 0);
      @(negedge clk);

      // Throughput: 16 back-to-back fetches, responses in order every cycle
      for (int i = 0; i < 17; i++) begin
         drive(i < 16, 12'(i * 4), 0, 0, 12'h000, 32'h0, 0);
         #1;
         chk($sformatf("tp%0d_fgnt", i), 32'(fetch_gnt), 32'(i < 16));
         if (i > 0) begin
            chk($sformatf("tp%0d_frv", i),  32'(fetch_rvalid), 1);
            chk($sformatf("tp%0d_fdat", i), fetch_rdata, exp_word(i - 1));
         end
         @(negedge clk);
      end
      #1;
      chk("tp_end_frv", 32'(fetch_rvalid), 0);

      // Reset mid-operation: build up starvation, leave a fetch read in flight
      for (int j = 0; j < 3; j++) begin
         drive(1, 12'h000, 1, 0, 12'h008, 32'h0, 0);
         #1;
         chk($sformatf("pre%0d_fgnt", j), 32'(fetch_gnt), 1);
         @(negedge clk);
      end
      rst = 1'b1;
      drive(0, 12'h000, 0, 0, 12'h000, 32'h0, 0);
      #1;
      chk("mid_frv",    32'(fetch_rvalid), 0);
      chk("mid_boot",   32'(boot), 1);
      chk("mid_mem_en", 32'(mem_en), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 12'h000, 0, 0, 12'h000, 32'h0, 1);
      #1;
      chk("post_fgnt_boot", 32'(fetch_gnt), 0);
      chk("post_frv",       32'(fetch_rvalid), 0);
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         drive(1, 12'h000, 1, 0, 12'h008, 32'h0, 0);
         #1;
         if (i == 0) chk("post_boot", 32'(boot), 0);
         chk($sformatf("post%0d_lgnt", i), 32'(load_gnt), 32'(i == 8));
         @(negedge clk);
      end
      drive(0, 12'h000, 0, 0, 12'h000, 32'h0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
